// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, register-file constants and the load-use detector.
package hazard_ctrl_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned XLen     = 64;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    localparam logic [RegAddrW-1:0] RegX0 = '0;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHold = 1'b1
    } hc_state_e;

    function automatic logic load_use_hazard(
        input logic [RegAddrW-1:0] rs1,
        input logic [RegAddrW-1:0] rs2,
        input logic                use_rs1,
        input logic                use_rs2,
        input logic [RegAddrW-1:0] rd,
        input logic                mem_read
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = use_rs1 && (rs1 == rd);
        rs2_hit = use_rs2 && (rs2 == rd);
        return mem_read && (rd != RegX0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline is the master (drives ID/EX status), the controller is the slave.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [RegAddrW-1:0] ID_rs1;
    logic [RegAddrW-1:0] ID_rs2;
    logic                ID_use_rs1;
    logic                ID_use_rs2;
    logic [RegAddrW-1:0] ID_EX_rd;
    logic                ID_EX_mem_read;
    logic                branch_taken;
    logic [XLen-1:0]     branch_target;
    logic                dmem_busy;

    logic                pc_write;
    logic                IF_ID_write;
    logic                IF_ID_flush;
    logic                ID_EX_flush;
    logic                pipe_hold;
    logic                pc_redirect;
    logic [XLen-1:0]     redirect_pc;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_mem_read,
        output branch_taken, branch_target, dmem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
        input  pc_redirect, redirect_pc
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_mem_read,
        input  branch_taken, branch_target, dmem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
        output pc_redirect, redirect_pc
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Clear wins over a same-cycle increment; the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + One;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory freezes and branch flushes.
// A redirect arriving while memory is busy is parked and replayed on the first free cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctr_clear,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hc_state_e       state_q;
    logic            pend_flush_q;
    logic [XLen-1:0] pend_target_q;

    logic load_use;
    logic flush_now;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_hold;
    logic pc_redirect;

    assign load_use = load_use_hazard(hz.ID_rs1, hz.ID_rs2, hz.ID_use_rs1, hz.ID_use_rs2,
                                      hz.ID_EX_rd, hz.ID_EX_mem_read);

    assign flush_now = (hz.branch_taken || pend_flush_q) && !hz.dmem_busy;

    // Mode tracking and the parked redirect share one sequential block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            pend_flush_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            unique case (state_q)
                StRun:   if (hz.dmem_busy)  state_q <= StHold;
                StHold:  if (!hz.dmem_busy) state_q <= StRun;
                default: state_q <= StRun;
            endcase

            if (hz.dmem_busy && hz.branch_taken) begin
                pend_flush_q  <= 1'b1;
                pend_target_q <= hz.branch_target;
            end else if (flush_now) begin
                pend_flush_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        pc_redirect = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hz.dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (flush_now) begin
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_redirect = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.IF_ID_write = if_id_write;
    assign hz.IF_ID_flush = if_id_flush;
    assign hz.ID_EX_flush = id_ex_flush;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.pc_redirect = pc_redirect;
    assign hz.redirect_pc = hz.branch_taken ? hz.branch_target : pend_target_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!reset && !pc_write),
        .clr   (ctr_clear),
        .cnt   (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!reset && flush_now),
        .clr   (ctr_clear),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level model of the controller.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // Control vector order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold, pc_redirect}
    localparam logic [5:0] CtlReset = 6'b001100;
    localparam logic [5:0] CtlBusy  = 6'b000010;
    localparam logic [5:0] CtlFlush = 6'b101101;
    localparam logic [5:0] CtlStall = 6'b000100;
    localparam logic [5:0] CtlRun   = 6'b110000;
    localparam int         CntMax   = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctr_clear;
    logic        ctr_clear4;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    bit          m_pend = 1'b0;
    logic [63:0] m_target = '0;
    int          m_stall = 0;
    int          m_flush = 0;

    hazard_ctrl_if hif ();
    hazard_ctrl_if hif4 ();

    hazard_ctrl #(
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctr_clear (ctr_clear),
        .hz        (hif),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    hazard_ctrl #(
        .CNT_W (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .ctr_clear (ctr_clear4),
        .hz        (hif4),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] act_ctl();
        return {hif.pc_write, hif.IF_ID_write, hif.IF_ID_flush, hif.ID_EX_flush,
                hif.pipe_hold, hif.pc_redirect};
    endfunction

    function automatic logic exp_flush_now();
        return !reset && !hif.dmem_busy && (hif.branch_taken || m_pend);
    endfunction

    function automatic logic [5:0] exp_ctl();
        logic hit1, hit2, lu;
        hit1 = hif.ID_use_rs1 && (hif.ID_rs1 == hif.ID_EX_rd);
        hit2 = hif.ID_use_rs2 && (hif.ID_rs2 == hif.ID_EX_rd);
        lu   = hif.ID_EX_mem_read && (hif.ID_EX_rd != 5'd0) && (hit1 || hit2);
        if (reset)                return CtlReset;
        else if (hif.dmem_busy)   return CtlBusy;
        else if (exp_flush_now()) return CtlFlush;
        else if (lu)              return CtlStall;
        else                      return CtlRun;
    endfunction

    function automatic logic [63:0] exp_rpc();
        return hif.branch_taken ? hif.branch_target : m_target;
    endfunction

    task automatic idle();
        hif.ID_rs1         = '0;
        hif.ID_rs2         = '0;
        hif.ID_use_rs1     = 1'b0;
        hif.ID_use_rs2     = 1'b0;
        hif.ID_EX_rd       = '0;
        hif.ID_EX_mem_read = 1'b0;
        hif.branch_taken   = 1'b0;
        hif.branch_target  = '0;
        hif.dmem_busy      = 1'b0;
        ctr_clear          = 1'b0;
    endtask

    // Advance the model by one clock using the inputs now applied, then step the DUT.
    task automatic tick();
        logic [5:0] e;
        logic       fn;
        e  = exp_ctl();
        fn = exp_flush_now();
        if (reset) begin
            m_pend = 1'b0; m_target = '0; m_stall = 0; m_flush = 0;
        end else begin
            if (ctr_clear) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e[5] && m_stall < CntMax) m_stall++;
                if (fn && m_flush < CntMax)    m_flush++;
            end
            if (hif.dmem_busy && hif.branch_taken) begin
                m_pend = 1'b1; m_target = hif.branch_target;
            end else if (fn) begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        hif.dmem_busy = 1'b1; hif.branch_taken = 1'b1; hif.branch_target = 64'h55;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlReset) begin
            n_bad++; $display("FAIL reset_ctl: got %b want %b", act_ctl(), CtlReset);
        end
        tick(); tick();
        reset = 1'b0; idle();
        #1;
        n_cmp++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        n_cmp++;
        if (act_ctl() !== CtlRun) begin
            n_bad++; $display("FAIL reset_release_ctl: got %b want %b", act_ctl(), CtlRun);
        end
        tick();
    endtask

    task automatic test_load_use();
        ctr_clear = 1'b1; tick(); idle();
        hif.ID_EX_mem_read = 1'b1; hif.ID_EX_rd = 5'd5;
        hif.ID_rs1 = 5'd5; hif.ID_use_rs1 = 1'b1;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlStall) begin
            n_bad++; $display("FAIL load_use_ctl: got %b want %b", act_ctl(), CtlStall);
        end
        tick(); idle();
        #1;
        n_cmp++;
        if (act_ctl() !== CtlRun || stall_cnt !== 16'd1) begin
            n_bad++; $display("FAIL load_use_after: got %b cnt %0d want %b cnt 1",
                              act_ctl(), stall_cnt, CtlRun);
        end
        // rs1 matches but is not read; rs2 is read and matches
        hif.ID_EX_mem_read = 1'b1; hif.ID_EX_rd = 5'd9;
        hif.ID_rs1 = 5'd9; hif.ID_use_rs1 = 1'b0;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlRun) begin
            n_bad++; $display("FAIL load_use_unused_rs1: got %b want %b", act_ctl(), CtlRun);
        end
        hif.ID_rs2 = 5'd9; hif.ID_use_rs2 = 1'b1;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlStall) begin
            n_bad++; $display("FAIL load_use_rs2: got %b want %b", act_ctl(), CtlStall);
        end
        tick(); idle();
    endtask

    task automatic test_x0_load();
        hif.ID_EX_mem_read = 1'b1; hif.ID_EX_rd = 5'd0;
        hif.ID_rs1 = 5'd0; hif.ID_use_rs1 = 1'b1;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlRun || hif.pc_write !== 1'b1) begin
            n_bad++; $display("FAIL x0_load: got %b want %b", act_ctl(), CtlRun);
        end
        tick(); idle();
    endtask

    task automatic test_branch_busy();
        ctr_clear = 1'b1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            hif.dmem_busy     = 1'b1;
            hif.branch_taken  = (i == 1);
            hif.branch_target = (i == 1) ? 64'h1000 : {$urandom(), $urandom()};
            #1;
            n_cmp++;
            if (act_ctl() !== CtlBusy) begin
                n_bad++; $display("FAIL busy_freeze[%0d]: got %b want %b", i, act_ctl(), CtlBusy);
            end
            tick();
        end
        hif.dmem_busy = 1'b0; hif.branch_taken = 1'b0; hif.branch_target = 64'hBAD0;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlFlush || hif.redirect_pc !== 64'h1000) begin
            n_bad++; $display("FAIL busy_replay: got %b pc %h want %b pc 1000",
                              act_ctl(), hif.redirect_pc, CtlFlush);
        end
        tick(); idle();
        #1;
        n_cmp++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3 || act_ctl() !== CtlRun) begin
            n_bad++; $display("FAIL busy_after: got flush %0d stall %0d ctl %b want 1 3 %b",
                              flush_cnt, stall_cnt, act_ctl(), CtlRun);
        end
        tick();
    endtask

    task automatic test_flush_wins();
        hif.ID_EX_mem_read = 1'b1; hif.ID_EX_rd = 5'd7;
        hif.ID_rs2 = 5'd7; hif.ID_use_rs2 = 1'b1;
        hif.branch_taken = 1'b1; hif.branch_target = 64'h2468;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlFlush || hif.redirect_pc !== 64'h2468) begin
            n_bad++; $display("FAIL flush_wins: got %b pc %h want %b pc 2468",
                              act_ctl(), hif.redirect_pc, CtlFlush);
        end
        tick(); idle();
    endtask

    task automatic test_back_to_back();
        hif.dmem_busy = 1'b1; hif.branch_taken = 1'b1; hif.branch_target = 64'hAAAA;
        tick();
        hif.branch_target = 64'hBBBB;
        tick();
        hif.dmem_busy = 1'b0; hif.branch_taken = 1'b0;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlFlush || hif.redirect_pc !== 64'hBBBB) begin
            n_bad++; $display("FAIL last_wins: got %b pc %h want %b pc bbbb",
                              act_ctl(), hif.redirect_pc, CtlFlush);
        end
        tick(); idle();
    endtask

    task automatic test_saturation();
        ctr_clear4 = 1'b1; tick(); ctr_clear4 = 1'b0;
        hif4.dmem_busy = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (stall_cnt4 !== 4'hF) begin
            n_bad++; $display("FAIL sat_stall: got %0d want 15", stall_cnt4);
        end
        ctr_clear4 = 1'b1;
        tick();
        n_cmp++;
        if (stall_cnt4 !== 4'h0) begin
            n_bad++; $display("FAIL sat_clear: got %0d want 0", stall_cnt4);
        end
        hif4.dmem_busy = 1'b0; ctr_clear4 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        hif.dmem_busy = 1'b1; hif.branch_taken = 1'b1; hif.branch_target = 64'hDEAD0000;
        tick();
        hif.branch_taken = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; hif.dmem_busy = 1'b0;
        #1;
        n_cmp++;
        if (act_ctl() !== CtlRun || hif.pc_redirect !== 1'b0) begin
            n_bad++; $display("FAIL reset_hold_ctl: got %b want %b", act_ctl(), CtlRun);
        end
        n_cmp++;
        if (dut.state_q !== StRun || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_hold_state: got st %0d cnt %0d/%0d want 0 0/0",
                              dut.state_q, stall_cnt, flush_cnt);
        end
        tick(); idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset              = ($urandom_range(0, 49) == 0);
            ctr_clear          = ($urandom_range(0, 29) == 0);
            hif.ID_rs1         = 5'($urandom_range(0, 3));
            hif.ID_rs2         = 5'($urandom_range(0, 3));
            hif.ID_use_rs1     = 1'($urandom_range(0, 1));
            hif.ID_use_rs2     = 1'($urandom_range(0, 1));
            hif.ID_EX_rd       = 5'($urandom_range(0, 3));
            hif.ID_EX_mem_read = 1'($urandom_range(0, 1));
            hif.branch_taken   = ($urandom_range(0, 3) == 0);
            hif.branch_target  = {$urandom(), $urandom()};
            hif.dmem_busy      = ($urandom_range(0, 2) == 0);
            #1;
            n_cmp++;
            if (act_ctl() !== exp_ctl()) begin
                n_bad++; $display("FAIL rand_ctl[%0d]: got %b want %b", c, act_ctl(), exp_ctl());
            end
            n_cmp++;
            if (hif.redirect_pc !== exp_rpc()) begin
                n_bad++; $display("FAIL rand_rpc[%0d]: got %h want %h", c, hif.redirect_pc,
                                  exp_rpc());
            end
            n_cmp++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                n_bad++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", c,
                                  stall_cnt, flush_cnt, m_stall, m_flush);
            end
            tick();
        end
        reset = 1'b0; idle();
    endtask

    initial begin
        ctr_clear4          = 1'b0;
        hif4.ID_rs1         = '0;
        hif4.ID_rs2         = '0;
        hif4.ID_use_rs1     = 1'b0;
        hif4.ID_use_rs2     = 1'b0;
        hif4.ID_EX_rd       = '0;
        hif4.ID_EX_mem_read = 1'b0;
        hif4.branch_taken   = 1'b0;
        hif4.branch_target  = '0;
        hif4.dmem_busy      = 1'b0;

        test_reset();
        test_load_use();
        test_x0_load();
        test_branch_busy();
        test_flush_wins();
        test_back_to_back();
        test_saturation();
        test_reset_mid_hold();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating performance counters.
REQ-002 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 Port: ID_use_rs1, ID_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 Port: ID_EX_rd  in  5  destination register of the instruction in EX.
REQ-007 Port: ID_EX_mem_read  in  1  EX instruction is a load.
REQ-008 Port: branch_taken  in  1  one-cycle pulse from EX: taken branch or jump resolved.
REQ-009 Port: branch_target  in  64  redirect PC; valid with branch_taken.
REQ-010 Port: dmem_busy  in  1  data memory not ready; the pipeline freezes while high.
REQ-011 Port: ctr_clear  in  1  synchronous clear of the performance counters.
REQ-012 Port: pc_write  out  1  PC register write enable.
REQ-013 Port: IF_ID_write  out  1  IF/ID register write enable.
REQ-014 Port: IF_ID_flush  out  1  zero the IF/ID register.
REQ-015 Port: ID_EX_flush  out  1  insert a bubble into ID/EX.
REQ-016 Port: pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-017 Port: pc_redirect  out  1  PC mux selects redirect_pc.
REQ-018 Port: redirect_pc  out  64  target to load into the PC.
REQ-019 Port: stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-020 load_use SHALL be ID_EX_mem_read and ID_EX_rd!=0 and ((ID_use_rs1 and rs1==rd) or (ID_use_rs2 and rs2==rd)).
REQ-021 FSM SHALL have two states: RUN, which goes to HOLD when dmem_busy=1, and HOLD, which goes to RUN when dmem_busy=0.
REQ-022 While dmem_busy=1 (either state), outputs SHALL be: pipe_hold=1, pc_write=0, IF_ID_write=0, no flush, pc_redirect=0.
REQ-023 branch_taken while dmem_busy=1 SHALL set pend_flush and capture branch_target in pend_target; a later pulse while pending SHALL overwrite both (last wins).
REQ-024 flush_now SHALL be (branch_taken or pend_flush) and dmem_busy=0; redirect_pc SHALL be branch_target when branch_taken=1, else pend_target.
REQ-025 When flush_now=1: IF_ID_flush=1, ID_EX_flush=1, pc_redirect=1, pc_write=1, IF_ID_write=0, and pend_flush clears at the next edge.
REQ-026 When load_use=1, flush_now=0 and dmem_busy=0: pc_write=0, IF_ID_write=0, ID_EX_flush=1, for exactly that cycle (combinational, zero latency).
REQ-027 Priority SHALL be reset > dmem_busy > flush_now > load_use > normal; a flush overrides a simultaneous load-use stall.
REQ-028 Normal operation SHALL be pc_write=1, IF_ID_write=1, with all other control outputs 0.
REQ-029 stall_cnt SHALL increment each cycle pc_write=0 while reset=0, saturating at all-ones with no wrap.
REQ-030 flush_cnt SHALL increment each cycle flush_now=1, saturating at all-ones.
REQ-031 ctr_clear SHALL zero both counters at the next edge and take precedence over a same-cycle increment.
REQ-032 All control outputs SHALL be combinational from inputs and registered state; there SHALL be no registered output latency.

Reset
REQ-033 reset SHALL clear state to RUN, pend_flush=0, pend_target=0 and both counters=0 at the next edge.
REQ-034 While reset=1, outputs SHALL be: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, pipe_hold=0, pc_redirect=0.
REQ-035 reset asserted during HOLD with a pending flush SHALL discard the pending redirect.

Structure
REQ-036 The FSM state encoding and the x0 register constant SHALL live in the shared pipeline package.
REQ-037 The two saturating counters SHALL be instances of one sub-module, sat_counter (inc, clr, CNT_W).

Verification
REQ-038 Load-use: ID_EX_mem_read=1, rd=5, rs1=5, use_rs1=1 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt=1.
REQ-039 x0 load: rd=0, rs1=0 -> no stall; pc_write=1.
REQ-040 Branch during busy: dmem_busy high for 3 cycles, branch_taken pulse at cycle 1 with target 0x1000 -> outputs frozen for 3 cycles; first free cycle gives pc_redirect=1, redirect_pc=0x1000 and both flushes; flush_cnt=1.
REQ-041 Branch and load-use in the same cycle -> flush wins: pc_write=1, pc_redirect=1, IF_ID_write=0.
REQ-042 CNT_W=4, hold for 20 cycles -> stall_cnt=15 (saturated); ctr_clear -> 0.
REQ-043 Reset mid-HOLD with a pending flush -> after release there is no redirect, state is RUN and counters are 0.
